// File: rtl/axis_latency_monitor.sv
// Passive per-channel request-latency monitor for AXI-Stream stream pairs.
// Timestamps the first accepted input beat of each request and matches it with
// the output beat that carries tlast. Keeps count/min/max/sum/last per channel.
module axis_latency_monitor #(
    parameter  int unsigned CHANNELS = 4,
    parameter  int unsigned CNT_W    = 32,
    parameter  int unsigned SUM_W    = 48,
    parameter  int unsigned DEPTH    = 4,
    localparam int unsigned SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clear,
    input  logic [CHANNELS-1:0]       s_tvalid,
    input  logic [CHANNELS-1:0]       s_tready,
    input  logic [CHANNELS-1:0]       s_tlast,
    input  logic [CHANNELS-1:0]       m_tvalid,
    input  logic [CHANNELS-1:0]       m_tready,
    input  logic [CHANNELS-1:0]       m_tlast,
    output logic [CHANNELS-1:0]       lat_valid,
    output logic [CNT_W*CHANNELS-1:0] lat_value,
    input  logic [SEL_W-1:0]          rd_sel,
    output logic [CNT_W-1:0]          rd_count,
    output logic [CNT_W-1:0]          rd_min,
    output logic [CNT_W-1:0]          rd_max,
    output logic [SUM_W-1:0]          rd_sum,
    output logic [1:0]                rd_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [AW:0]      ptr_t;

    cnt_t                ts_q;
    cnt_t                mem_q    [CHANNELS][DEPTH];
    ptr_t                wptr_q   [CHANNELS];
    ptr_t                wptr_d   [CHANNELS];
    ptr_t                rptr_q   [CHANNELS];
    ptr_t                rptr_d   [CHANNELS];
    logic [CHANNELS-1:0] in_pkt_q, in_pkt_d;
    logic [CHANNELS-1:0] lat_valid_q, lat_valid_d;
    logic [CHANNELS-1:0] push;
    cnt_t                count_q  [CHANNELS];
    cnt_t                count_d  [CHANNELS];
    cnt_t                min_q    [CHANNELS];
    cnt_t                min_d    [CHANNELS];
    cnt_t                max_q    [CHANNELS];
    cnt_t                max_d    [CHANNELS];
    cnt_t                last_q   [CHANNELS];
    cnt_t                last_d   [CHANNELS];
    logic [SUM_W-1:0]    sum_q    [CHANNELS];
    logic [SUM_W-1:0]    sum_d    [CHANNELS];
    logic [1:0]          err_q    [CHANNELS];
    logic [1:0]          err_d    [CHANNELS];

    // Free-running timestamp; only reset zeroes it, clear leaves it running.
    always_ff @(posedge clock) begin
        if (reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    // Per-channel start/end detection, FIFO occupancy and statistics update.
    always_comb begin : next_state
        ptr_t             occ;
        cnt_t             lat;
        logic [SUM_W:0]   sum_ext;
        logic             acc_s, start, fin, empty, full;
        occ     = '0;
        lat     = '0;
        sum_ext = '0;
        acc_s   = 1'b0;
        start   = 1'b0;
        fin     = 1'b0;
        empty   = 1'b0;
        full    = 1'b0;
        in_pkt_d    = in_pkt_q;
        lat_valid_d = '0;
        push        = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            wptr_d[c] = wptr_q[c];
            rptr_d[c] = rptr_q[c];
            count_d[c] = count_q[c];
            min_d[c]   = min_q[c];
            max_d[c]   = max_q[c];
            last_d[c]  = last_q[c];
            sum_d[c]   = sum_q[c];
            err_d[c]   = err_q[c];

            acc_s = s_tvalid[c] & s_tready[c];
            start = acc_s & ~in_pkt_q[c];
            fin   = m_tvalid[c] & m_tready[c] & m_tlast[c];
            occ   = wptr_q[c] - rptr_q[c];
            empty = (occ == '0);
            full  = (occ == ptr_t'(DEPTH));
            lat   = ts_q - mem_q[c][rptr_q[c][AW-1:0]];
            sum_ext = {1'b0, sum_q[c]} + {{(SUM_W + 1 - CNT_W){1'b0}}, lat};

            if (acc_s) begin
                in_pkt_d[c] = ~s_tlast[c];
            end

            // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
            if (start) begin
                if (!full || fin) begin
                    push[c]   = 1'b1;
                    wptr_d[c] = wptr_q[c] + 1'b1;
                end else begin
                    err_d[c][0] = 1'b1;
                end
            end

            if (fin) begin
                if (empty) begin
                    err_d[c][1] = 1'b1;
                end else begin
                    rptr_d[c]      = rptr_q[c] + 1'b1;
                    lat_valid_d[c] = 1'b1;
                    last_d[c]      = lat;
                    count_d[c]     = (count_q[c] == '1) ? count_q[c] : count_q[c] + 1'b1;
                    sum_d[c]       = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
                    if (lat < min_q[c]) begin
                        min_d[c] = lat;
                    end
                    if (lat > max_q[c]) begin
                        max_d[c] = lat;
                    end
                end
            end
        end
    end

    // Per-channel state registers; reset and clear override any handshake.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            in_pkt_q    <= '0;
            lat_valid_q <= '0;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                wptr_q[c]  <= '0;
                rptr_q[c]  <= '0;
                count_q[c] <= '0;
                min_q[c]   <= '1;
                max_q[c]   <= '0;
                last_q[c]  <= '0;
                sum_q[c]   <= '0;
                err_q[c]   <= '0;
            end
        end else begin
            in_pkt_q    <= in_pkt_d;
            lat_valid_q <= lat_valid_d;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                wptr_q[c]  <= wptr_d[c];
                rptr_q[c]  <= rptr_d[c];
                count_q[c] <= count_d[c];
                min_q[c]   <= min_d[c];
                max_q[c]   <= max_d[c];
                last_q[c]  <= last_d[c];
                sum_q[c]   <= sum_d[c];
                err_q[c]   <= err_d[c];
            end
        end
    end

    // Timestamp storage; stale entries are harmless because pointers are reset.
    always_ff @(posedge clock) begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (push[c]) begin
                mem_q[c][wptr_q[c][AW-1:0]] <= ts_q;
            end
        end
    end

    // Registered readout of the selected channel's statistics.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            rd_count <= '0;
            rd_min   <= '1;
            rd_max   <= '0;
            rd_sum   <= '0;
            rd_err   <= '0;
        end else if (32'(rd_sel) < CHANNELS) begin
            rd_count <= count_q[rd_sel];
            rd_min   <= min_q[rd_sel];
            rd_max   <= max_q[rd_sel];
            rd_sum   <= sum_q[rd_sel];
            rd_err   <= err_q[rd_sel];
        end
    end

    // Pack the most recent latency of every channel onto the flat output bus.
    always_comb begin
        lat_value = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            lat_value[c*CNT_W +: CNT_W] = last_q[c];
        end
    end

    assign lat_valid = lat_valid_q;

endmodule

// File: tb/tb_axis_latency_monitor.sv
// Self-checking bench for axis_latency_monitor: directed scenarios followed by
// random traffic, compared against a queue-based reference model.
module tb_axis_latency_monitor;

    localparam int unsigned CH = 4;
    localparam int unsigned CW = 8;
    localparam int unsigned SW = 16;
    localparam int unsigned DP = 4;

    logic          clock = 1'b0;
    logic          reset, clear;
    logic [CH-1:0] s_tvalid, s_tready, s_tlast;
    logic [CH-1:0] m_tvalid, m_tready, m_tlast;
    logic [CH-1:0] lat_valid;
    logic [CW*CH-1:0] lat_value;
    logic [1:0]    rd_sel;
    logic [CW-1:0] rd_count, rd_min, rd_max;
    logic [SW-1:0] rd_sum;
    logic [1:0]    rd_err;

    always #5 clock = ~clock;

    axis_latency_monitor #(
        .CHANNELS(CH),
        .CNT_W   (CW),
        .SUM_W   (SW),
        .DEPTH   (DP)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tlast  (s_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tlast  (m_tlast),
        .lat_valid(lat_valid),
        .lat_value(lat_value),
        .rd_sel   (rd_sel),
        .rd_count (rd_count),
        .rd_min   (rd_min),
        .rd_max   (rd_max),
        .rd_sum   (rd_sum),
        .rd_err   (rd_err)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: a queue of pending timestamps per channel plus plain stats.
    typedef int q_t[$];
    q_t      m_q[CH];
    int      m_ts;
    bit      m_inpkt[CH];
    int      m_cnt[CH], m_min[CH], m_max[CH], m_sum[CH], m_last[CH];
    bit [1:0] m_err[CH];
    bit [CH-1:0] m_lv;
    int      r_cnt, r_min, r_max, r_sum;
    bit [1:0] r_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < CH; c++) begin
            m_q[c].delete();
            m_inpkt[c] = 1'b0;
            m_cnt[c]   = 0;
            m_min[c]   = 255;
            m_max[c]   = 0;
            m_sum[c]   = 0;
            m_last[c]  = 0;
            m_err[c]   = 2'b00;
        end
        m_lv  = '0;
        r_cnt = 0;
        r_min = 255;
        r_max = 0;
        r_sum = 0;
        r_err = 2'b00;
    endtask

    // Applies one clock edge worth of the monitor's rules to the model.
    task automatic model_edge();
        int  n, lat;
        bit  sacc, start, fin;
        if (reset || clear) begin
            model_clear();
            m_ts = reset ? 0 : (m_ts + 1) % 256;
            return;
        end
        r_cnt = m_cnt[rd_sel];
        r_min = m_min[rd_sel];
        r_max = m_max[rd_sel];
        r_sum = m_sum[rd_sel];
        r_err = m_err[rd_sel];
        for (int c = 0; c < CH; c++) begin
            m_lv[c] = 1'b0;
            sacc  = s_tvalid[c] && s_tready[c];
            start = sacc && !m_inpkt[c];
            fin   = m_tvalid[c] && m_tready[c] && m_tlast[c];
            n     = m_q[c].size();
            if (fin) begin
                if (n == 0) begin
                    m_err[c][1] = 1'b1;
                end else begin
                    lat = (m_ts - m_q[c].pop_front()) & 255;
                    m_lv[c]   = 1'b1;
                    m_last[c] = lat;
                    m_cnt[c]  = (m_cnt[c] == 255) ? 255 : m_cnt[c] + 1;
                    m_sum[c]  = (m_sum[c] + lat > 65535) ? 65535 : m_sum[c] + lat;
                    if (lat < m_min[c]) m_min[c] = lat;
                    if (lat > m_max[c]) m_max[c] = lat;
                end
            end
            if (start) begin
                if (n < DP || fin) m_q[c].push_back(m_ts);
                else m_err[c][0] = 1'b1;
            end
            if (sacc) m_inpkt[c] = !s_tlast[c];
        end
        m_ts = (m_ts + 1) % 256;
    endtask

    task automatic compare_all();
        logic [CW*CH-1:0] exp_val;
        int tmp;
        exp_val = '0;
        for (int c = 0; c < CH; c++) begin
            tmp = m_last[c];
            exp_val[c*CW +: CW] = tmp[CW-1:0];
        end
        chk("lat_valid", lat_valid, m_lv);
        chk("lat_value", lat_value, exp_val);
        chk("rd_count", rd_count, r_cnt);
        chk("rd_min", rd_min, r_min);
        chk("rd_max", rd_max, r_max);
        chk("rd_sum", rd_sum, r_sum);
        chk("rd_err", rd_err, r_err);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle();
        s_tvalid = '0; s_tready = '0; s_tlast = '0;
        m_tvalid = '0; m_tready = '0; m_tlast = '0;
    endtask

    task automatic wait_ts(input int t);
        for (int i = 0; i < 300 && m_ts != t; i++) step();
        if (m_ts != t) begin
            failures++;
            $display("FAIL wait_ts observed=%0d expected=%0d", m_ts, t);
        end
    endtask

    task automatic beat_in(input int c, input bit last);
        s_tvalid[c] = 1'b1; s_tready[c] = 1'b1; s_tlast[c] = last;
    endtask

    task automatic beat_out(input int c);
        m_tvalid[c] = 1'b1; m_tready[c] = 1'b1; m_tlast[c] = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; clear = 1'b0; rd_sel = 2'd0;
        idle();
        model_clear();
        m_ts = 0;
        step();
        step();
        chk("rst_count", rd_count, 0);
        chk("rst_min", rd_min, 8'hFF);
        chk("rst_lat_valid", lat_valid, 4'b0000);
        reset = 1'b0;

        // Scenario 1: single request on ch0, ts 10 -> 59.
        wait_ts(10);
        beat_in(0, 1'b1); step(); idle();
        wait_ts(59);
        beat_out(0); step(); idle();
        chk("t1_lv", lat_valid[0], 1'b1);
        chk("t1_lat", lat_value[7:0], 49);
        step();
        chk("t1_lv_off", lat_valid[0], 1'b0);
        chk("t1_count", rd_count, 1);
        chk("t1_min", rd_min, 49);
        chk("t1_max", rd_max, 49);
        chk("t1_sum", rd_sum, 49);

        // Scenario 2: three in-order requests on ch1.
        for (int k = 0; k < 3; k++) begin
            wait_ts(100 + 10 * k);
            beat_in(1, 1'b1); step(); idle();
        end
        for (int k = 0; k < 3; k++) begin
            wait_ts(200 + 15 * k);
            beat_out(1); step(); idle();
            chk("t2_lv", lat_valid[1], 1'b1);
            chk("t2_lat", lat_value[15:8], 100 + 5 * k);
        end
        rd_sel = 2'd1;
        step();
        chk("t2_count", rd_count, 3);
        chk("t2_min", rd_min, 100);
        chk("t2_max", rd_max, 110);
        chk("t2_sum", rd_sum, 315);

        // Scenario 3: ch2 overflow then full drain.
        rd_sel = 2'd2;
        for (int k = 0; k < 5; k++) begin
            beat_in(2, 1'b1); step();
        end
        idle(); step();
        chk("t3_ovf", rd_err, 2'b01);
        for (int k = 0; k < 4; k++) begin
            beat_out(2); step();
        end
        idle(); step();
        chk("t3_count", rd_count, 4);
        chk("t3_err", rd_err, 2'b01);

        // Scenario 4: ch3 underflow, then clear.
        rd_sel = 2'd3;
        beat_out(3); step(); idle();
        chk("t4_no_lv", lat_valid[3], 1'b0);
        step();
        chk("t4_unf", rd_err, 2'b10);
        chk("t4_count", rd_count, 0);
        clear = 1'b1; step(); clear = 1'b0;
        step();
        chk("t4_clr_err", rd_err, 2'b00);
        chk("t4_clr_min", rd_min, 8'hFF);

        // Scenario 5: timestamp wrap, 250 -> 4.
        wait_ts(250);
        beat_in(0, 1'b1); step(); idle();
        wait_ts(4);
        beat_out(0); step(); idle();
        chk("t5_lv", lat_valid[0], 1'b1);
        chk("t5_lat", lat_value[7:0], 10);

        // Scenario 6: start+end on full FIFOs of ch0/ch1, then a 3-beat packet on ch2.
        for (int k = 0; k < 4; k++) begin
            beat_in(0, 1'b1); beat_in(1, 1'b1); step();
        end
        beat_out(0); beat_out(1); step(); idle();
        chk("t6_lv", lat_valid[1:0], 2'b11);
        rd_sel = 2'd0; step();
        chk("t6_err0", rd_err, 2'b00);
        rd_sel = 2'd1; step();
        chk("t6_err1", rd_err, 2'b00);
        beat_in(2, 1'b0); step();
        s_tready[2] = 1'b0; step();
        beat_in(2, 1'b0); step();
        beat_in(2, 1'b1); step(); idle();
        beat_out(2); step();
        chk("t6_pkt_lv", lat_valid[2], 1'b1);
        step(); idle();
        chk("t6_pkt_lv2", lat_valid[2], 1'b0);
        rd_sel = 2'd2; step();
        chk("t6_pkt_count", rd_count, 1);
        chk("t6_pkt_err", rd_err, 2'b10);

        // Random traffic with occasional clear/reset.
        clear = 1'b1; step(); clear = 1'b0;
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < CH; c++) begin
                s_tvalid[c] = ($urandom_range(0, 2) != 0);
                s_tready[c] = ($urandom_range(0, 2) != 0);
                s_tlast[c]  = ($urandom_range(0, 2) == 0);
                m_tvalid[c] = ($urandom_range(0, 3) == 0);
                m_tready[c] = ($urandom_range(0, 2) != 0);
                m_tlast[c]  = ($urandom_range(0, 1) == 0);
            end
            rd_sel = 2'($urandom_range(0, 3));
            clear  = ($urandom_range(0, 149) == 0);
            reset  = ($urandom_range(0, 399) == 0);
            step();
        end
        reset = 1'b0; clear = 1'b0; idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
